// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and defaults for the main-memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam int LOCK_TIMEOUT_DEF = 64;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - pure 2-way round-robin picker; rr_last names the master served last
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic gnt0,
  output logic gnt1
);

  // On a tie the master that was not served last wins.
  assign gnt0 = req0 & (~req1 | rr_last);
  assign gnt1 = req1 & (~req0 | ~rr_last);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter with lock for the single-port SPRAM
// MEM_ARB_WATCHDOG_EN: breaks locks held longer than LOCK_TIMEOUT cycles and pulses lock_err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic              m0_we,
  input  logic [3:0]        m0_wmask,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_we,
  input  logic [3:0]        m1_wmask,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              mem_wren,
  output logic [3:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              lock_err
);

  arb_state_e        state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic              pick0, pick1;
  logic              gnt0, gnt1;
  logic              timeout;
  logic [1:0]        ign_lock;

  rr_pick2 u_pick (
    .req0    (m0_req),
    .req1    (m1_req),
    .rr_last (rr_last_q),
    .gnt0    (pick0),
    .gnt1    (pick1)
  );

`ifdef MEM_ARB_WATCHDOG_EN
  localparam logic [6:0] CNT_LAST = 7'(LOCK_TIMEOUT - 1);

  logic [6:0] lock_cnt_q, lock_cnt_d;
  logic [1:0] ign_lock_q, ign_lock_d;

  assign timeout  = (state_q != ARB) && (lock_cnt_q == CNT_LAST);
  assign lock_err = rstn & timeout;
  assign ign_lock = ign_lock_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lock_cnt_q <= '0;
      ign_lock_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      ign_lock_q <= ign_lock_d;
    end
  end

  // A master whose lock was broken gets one unlocked access so the other side can progress.
  always_comb begin
    lock_cnt_d = (state_q == ARB) ? 7'd0 : lock_cnt_q + 7'd1;
    ign_lock_d = ign_lock_q;
    if (gnt0) ign_lock_d[0] = 1'b0;
    if (gnt1) ign_lock_d[1] = 1'b0;
    if (timeout) begin
      lock_cnt_d = 7'd0;
      if (state_q == LOCK1) ign_lock_d[1] = 1'b1;
      else                  ign_lock_d[0] = 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign timeout    = 1'b0;
  assign ign_lock   = 2'b00;
  assign lock_err   = 1'b0;
  assign unused_cfg = ^7'(LOCK_TIMEOUT);
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ARB;
      rr_last_q   <= M_DMA;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    m0_rvalid_d = gnt0 & ~m0_we;
    m1_rvalid_d = gnt1 & ~m1_we;
    addr_d      = mem_addr;
    wdata_d     = mem_wdata;
    wmask_d     = mem_wmask;
    case (state_q)
      ARB: begin
        if (gnt0 && m0_lock && !ign_lock[0])      state_d = LOCK0;
        else if (gnt1 && m1_lock && !ign_lock[1]) state_d = LOCK1;
      end
      LOCK0: if ((gnt0 || !m0_req) && !m0_lock) state_d = ARB;
      LOCK1: if ((gnt1 || !m1_req) && !m1_lock) state_d = ARB;
      default: state_d = ARB;
    endcase
    if (gnt0) rr_last_d = M_CPU;
    if (gnt1) rr_last_d = M_DMA;
    if (timeout) begin
      state_d   = ARB;
      rr_last_d = (state_q == LOCK1) ? M_DMA : M_CPU;
    end
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rstn) begin
      case (state_q)
        ARB: begin
          gnt0 = pick0;
          gnt1 = pick1;
        end
        LOCK0:   gnt0 = m0_req;
        LOCK1:   gnt1 = m1_req;
        default: ;
      endcase
    end
    m0_gnt    = gnt0;
    m1_gnt    = gnt1;
    mem_wren  = (gnt0 & m0_we) | (gnt1 & m1_we);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wmask = wmask_q;
    if (gnt0) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_wmask = m0_wmask;
    end else if (gnt1) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_wmask = m1_wmask;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and random scoreboard bench for mem_arbiter with an SPRAM model
module tb_mem_arbiter;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rstn;
  logic          m0_req, m0_lock, m0_we, m1_req, m1_lock, m1_we;
  logic [3:0]    m0_wmask, m1_wmask;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          mem_wren;
  logic [3:0]    mem_wmask;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          lock_err;

  typedef struct {
    logic        m;
    logic [31:0] d;
  } rd_exp_t;

  rd_exp_t     sb_q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] ram[0:(1<<AW)-1];
  int          n_vec = 0;
  int          n_err = 0;
  logic        exp_lerr = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_wmask(m0_wmask),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_wmask(m1_wmask),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .mem_wren(mem_wren), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lock_err(lock_err)
  );

  // SPRAM stand-in: byte-masked write, registered read of the pre-write contents.
  initial for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_wren)
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m0(input logic req, input logic lk, input logic we, input logic [3:0] wm,
                        input logic [AW-1:0] a, input logic [31:0] wd);
    m0_req = req; m0_lock = lk; m0_we = we; m0_wmask = wm; m0_addr = a; m0_wdata = wd;
  endtask

  task automatic set_m1(input logic req, input logic lk, input logic we, input logic [3:0] wm,
                        input logic [AW-1:0] a, input logic [31:0] wd);
    m1_req = req; m1_lock = lk; m1_we = we; m1_wmask = wm; m1_addr = a; m1_wdata = wd;
  endtask

  // One bus cycle: check grant and memory side, update the model, then check read returns.
  task automatic tick(input logic e0, input logic e1);
    logic          we;
    logic [3:0]    wm;
    logic [AW-1:0] a;
    logic [31:0]   wd, cur;
    rd_exp_t       e;
    #1;
    chk("m0_gnt", 32'(m0_gnt), 32'(e0));
    chk("m1_gnt", 32'(m1_gnt), 32'(e1));
    chk("lock_err", 32'(lock_err), 32'(exp_lerr));
    if (e0 || e1) begin
      we = e0 ? m0_we    : m1_we;
      wm = e0 ? m0_wmask : m1_wmask;
      a  = e0 ? m0_addr  : m1_addr;
      wd = e0 ? m0_wdata : m1_wdata;
      chk("mem_addr", 32'(mem_addr), 32'(a));
      chk("mem_wren", 32'(mem_wren), 32'(we));
      cur = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
      if (we) begin
        chk("mem_wdata", mem_wdata, wd);
        chk("mem_wmask", 32'(mem_wmask), 32'(wm));
        for (int b = 0; b < 4; b++) if (wm[b]) cur[8*b +: 8] = wd[8*b +: 8];
        ref_mem[int'(a)] = cur;
      end else begin
        e.m = e1;
        e.d = cur;
        sb_q.push_back(e);
      end
    end else begin
      chk("mem_wren_idle", 32'(mem_wren), 32'h0);
    end
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("rvalid_hit",  32'(e.m ? m1_rvalid : m0_rvalid), 32'h1);
      chk("rvalid_other", 32'(e.m ? m0_rvalid : m1_rvalid), 32'h0);
      chk("rdata", e.m ? m1_rdata : m0_rdata, e.d);
    end else begin
      chk("m0_rvalid_none", 32'(m0_rvalid), 32'h0);
      chk("m1_rvalid_none", 32'(m1_rvalid), 32'h0);
    end
  endtask

  initial begin
    // Reset with both masters requesting
    rstn = 1'b0;
    set_m0(1'b1, 1'b0, 1'b1, 4'hF, 14'h00, 32'h1111_1111);
    set_m1(1'b1, 1'b0, 1'b0, 4'hF, 14'h10, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'h0);
    chk("rst_wren", 32'(mem_wren), 32'h0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
    chk("rst_lock_err", 32'(lock_err), 32'h0);
    m0_we = 1'b0;
    rstn  = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    set_m0(1'b0, 1'b0, 1'b0, 4'hF, 14'h3F, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 4'hF, 14'h3E, 32'h0);
    tick(1'b0, 1'b0);
    chk("mem_addr_hold", 32'(mem_addr), 32'h10);

    // Masked write then read-back
    set_m0(1'b1, 1'b0, 1'b1, 4'b0011, 14'h20, 32'hDEAD_BEEF);
    tick(1'b1, 1'b0);
    set_m0(1'b1, 1'b0, 1'b0, 4'b0000, 14'h20, 32'h0);
    tick(1'b1, 1'b0);
    set_m0(1'b0, 1'b0, 1'b0, 4'b0000, 14'h20, 32'h0);
    tick(1'b0, 1'b0);

    // m1 lock holds m0 off until m1 releases
    set_m0(1'b1, 1'b0, 1'b0, 4'h0, 14'h20, 32'h0);
    set_m1(1'b1, 1'b1, 1'b0, 4'h0, 14'h30, 32'h0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    set_m1(1'b0, 1'b0, 1'b0, 4'h0, 14'h30, 32'h0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);

    // Reset in LOCK0 with a read outstanding
    set_m0(1'b1, 1'b1, 1'b0, 4'h0, 14'h20, 32'h0);
    tick(1'b1, 1'b0);
    rstn  = 1'b0;
    m0_we = 1'b1;
    #1;
    chk("rstlk_m0_gnt", 32'(m0_gnt), 32'h0);
    chk("rstlk_wren", 32'(mem_wren), 32'h0);
    @(posedge clk); #1;
    chk("rstlk_m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("rstlk_m1_rvalid", 32'(m1_rvalid), 32'h0);
    rstn = 1'b1;
    set_m0(1'b0, 1'b0, 1'b0, 4'h0, 14'h20, 32'h0);
    set_m1(1'b1, 1'b0, 1'b0, 4'h0, 14'h10, 32'h0);
    tick(1'b0, 1'b1);

    // m0 holds lock indefinitely while m1 waits
    set_m0(1'b1, 1'b1, 1'b0, 4'h0, 14'h20, 32'h0);
    tick(1'b1, 1'b0);
`ifdef MEM_ARB_WATCHDOG_EN
    for (int i = 1; i <= 8; i++) begin
      exp_lerr = (i == 8);
      tick(1'b1, 1'b0);
    end
    exp_lerr = 1'b0;
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
`else
    for (int i = 1; i <= 20; i++) tick(1'b1, 1'b0);
    m0_lock = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
`endif

    // m0 alone: random masked writes and reads against the model
    set_m1(1'b0, 1'b0, 1'b0, 4'h0, 14'h10, 32'h0);
    for (int i = 0; i < 100; i++) begin
      set_m0(1'b1, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             14'(14'h40 + $urandom_range(0, 7)), $urandom);
      tick(1'b1, 1'b0);
    end
    set_m0(1'b0, 1'b0, 1'b0, 4'h0, 14'h40, 32'h0);
    tick(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter for the single-port main memory (2x SB_SPRAM256KA, 32-bit word, byte mask, 1-cycle read latency).
- Master 0 is the pipeline data/fetch port. Master 1 is a UART loader/DMA engine.
- Round-robin grant per cycle. A lock input holds ownership for atomic read-modify-write sequences.
- Sits between the address decoder and SPRAMMemory; the memory side is unchanged.

Parameters:
- ADDR_W, 14, word-address width to memory.
- LOCK_TIMEOUT, 64, max consecutive locked cycles. Used only with MEM_ARB_WATCHDOG_EN.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- m0_req  in  1  master 0 access request
- m0_lock  in  1  master 0 requests to keep ownership after this access
- m0_we  in  1  write (1) / read (0)
- m0_wmask  in  4  byte write mask
- m0_addr  in  ADDR_W  word address
- m0_wdata  in  32  write data
- m0_gnt  out  1  access accepted this cycle (combinational)
- m0_rvalid  out  1  read data valid (registered)
- m0_rdata  out  32  read data
- m1_req, m1_lock, m1_we, m1_wmask, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0.
- mem_wren  out  1  memory write enable
- mem_wmask  out  4  memory byte mask
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid 1 cycle after address
- lock_err  out  1  watchdog release pulse; constant 0 without macro

Behaviour:
- Reset (rstn=0 at clk edge): state=ARB, rr_last=1 (master 0 wins first tie), m*_rvalid=0, lock_err=0. With rstn low, gnt outputs are 0 and mem_wren=0.
- Grant is combinational:
  - m*_gnt is asserted in the same cycle as req.
  - A master holds req and its signals stable until it sees gnt.
  - gnt is never asserted without req.
- States:
  - ARB: req from one master only → grant it. Both requesting → grant !rr_last. Granted master with lock=1 → LOCK0/LOCK1.
  - LOCKn: only master n can be granted. The other master's req is held off (gnt=0). Leave to ARB on a granted cycle with lockn=0, or on a cycle with reqn=0 and lockn=0.
- rr_last updates to the granted index on every granted cycle.
- Memory mux:
  - mem_addr, mem_wdata and mem_wmask come from the granted master; they are held at their last value when idle.
  - mem_wren = gnt & we of the granted master.
- Reads:
  - A granted read with we=0 sets m*_rvalid=1 for that master in the next cycle.
  - m*_rdata = mem_rdata passthrough to both masters; only rvalid qualifies it.
  - Writes produce no rvalid.
- Throughput: one access per cycle. Back-to-back reads from alternating masters yield alternating rvalid with no bubble.
- A granted read and a new grant in the following cycle overlap legally.
- Reset mid-lock: returns to ARB. A pending rvalid is dropped.
- A write followed by a read to the same address in the next cycle returns the new data (SPRAM write-through not required; the memory is read after the write cycle).

Optional Feature:
- MEM_ARB_WATCHDOG_EN defined:
  - A 7-bit lock_cnt counts cycles in LOCKn and clears in ARB.
  - On lock_cnt==LOCK_TIMEOUT-1, force state to ARB and set rr_last=n so the other master wins next.
  - lock_err pulses high for 1 cycle.
  - lock is ignored for the next granted access of that master.
- Undefined: no counter; a lock may be held indefinitely; lock_err tied to 0.

Decomposition:
- Shared package mem_arb_pkg: state encoding (ARB=2'd0, LOCK0=2'd1, LOCK1=2'd2), master index constants M_CPU=0 and M_DMA=1, default LOCK_TIMEOUT.
- Sub-module rr_pick2: pure 2-way round-robin picker taking (req0, req1, rr_last) and producing (gnt0, gnt1). It is reusable by the peripheral bus. The FSM and datapath mux stay in mem_arbiter.

Test Plan:
1. Reset with both req=1, m1 addr=0x10 → m0 granted in the first cycle after reset; the next cycle grants m1; mem_addr alternates 0x00/0x10.
2. m0 writes 0xDEADBEEF with wmask=4'b0011 to 0x20, then reads 0x20 → m0_rvalid=1 one cycle after the read grant, data 0x0000BEEF over a zeroed word; m1_rvalid stays 0.
3. m1 lock=1 for 3 accesses while m0_req=1 throughout → m0_gnt=0 for those cycles; m0 granted in the cycle after m1 drops lock.
4. Rstn low for 1 cycle during LOCK0 with a read in flight → rvalid=0 after reset, state ARB, mem_wren=0.
5. MEM_ARB_WATCHDOG_EN, LOCK_TIMEOUT=8: m0 holds lock forever while m1 requests → lock_err pulses once at locked cycle 8; m1 granted the following cycle.
6. m0 only, 100 random reads/writes against a scoreboard model → every read returns the last written bytes; no rvalid without a grant.
